// File: rtl/pool_arbiter_if.sv
// Bus between the per-channel conv outputs, the shared subsample instance and the tagged-result sink.
// slave = arbiter side, master = environment side.
interface pool_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 12,
  parameter int POOL_SIZE  = 10
);
  localparam int CH_WIDTH  = $clog2(NUM_CH);
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(POOL_SIZE);

  logic [NUM_CH-1:0]            arb_valid_in;
  logic [NUM_CH-1:0]            arb_ready_in;
  logic [NUM_CH*DATA_WIDTH-1:0] arb_data_in;
  logic                         arb_valid_out;
  logic                         arb_ready_out;
  logic [DATA_WIDTH-1:0]        arb_data_out;
  logic                         res_valid_in;
  logic                         res_ready_in;
  logic [ACC_WIDTH-1:0]         res_data_in;
  logic                         res_valid_out;
  logic                         res_ready_out;
  logic [ACC_WIDTH-1:0]         res_data_out;
  logic [CH_WIDTH-1:0]          res_ch_out;

  modport slave (
    input  arb_valid_in, arb_data_in, arb_ready_out, res_valid_in, res_data_in, res_ready_out,
    output arb_ready_in, arb_valid_out, arb_data_out, res_ready_in, res_valid_out, res_data_out,
           res_ch_out
  );

  modport master (
    output arb_valid_in, arb_data_in, arb_ready_out, res_valid_in, res_data_in, res_ready_out,
    input  arb_ready_in, arb_valid_out, arb_data_out, res_ready_in, res_valid_out, res_data_out,
           res_ch_out
  );
endinterface

// File: rtl/pool_arbiter.sv
// Round-robin window arbiter sharing one subsample accumulator across NUM_CH channels; results tagged
// with their channel. Optional sticky error flag under POOL_ARB_ERR_EN.
module pool_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 12,
  parameter int POOL_SIZE  = 10
) (
  input  logic          clk,
  input  logic          rst,
  pool_arbiter_if.slave bus
`ifdef POOL_ARB_ERR_EN
  ,
  output logic          arb_err
`endif
);
  localparam int CH_WIDTH = $clog2(NUM_CH);
  localparam int CNT_W    = ($clog2(POOL_SIZE) > 0) ? $clog2(POOL_SIZE) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state_q;
  logic [CH_WIDTH-1:0] grant_q;
  logic [CH_WIDTH-1:0] grant_d;
  logic [CH_WIDTH-1:0] last_grant_q;
  logic [CH_WIDTH-1:0] cand;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic                pend_vld_q;
  logic [CH_WIDTH-1:0] pend_ch_q;
  logic                fire;
  logic                last_beat;
  logic                res_hs;

  // First requester strictly after last_grant, wrapping; lowest offset is assigned last so it wins.
  always_comb begin
    grant_d = grant_q;
    cand    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CH_WIDTH'((int'(last_grant_q) + k) % NUM_CH);
      if (bus.arb_valid_in[cand]) begin
        grant_d = cand;
      end
    end
  end

  always_comb begin
    bus.arb_ready_in  = '0;
    bus.arb_valid_out = 1'b0;
    bus.arb_data_out  = '0;
    if (state_q == LOCK) begin
      bus.arb_valid_out         = bus.arb_valid_in[grant_q];
      bus.arb_data_out          = bus.arb_data_in[grant_q*DATA_WIDTH +: DATA_WIDTH];
      bus.arb_ready_in[grant_q] = bus.arb_ready_out;
    end
  end

  assign bus.res_valid_out = bus.res_valid_in;
  assign bus.res_data_out  = bus.res_data_in;
  assign bus.res_ready_in  = bus.res_ready_out;
  assign bus.res_ch_out    = pend_ch_q;

  assign fire      = bus.arb_valid_out && bus.arb_ready_out;
  assign last_beat = fire && (beat_cnt_q == CNT_W'(POOL_SIZE - 1));
  assign res_hs    = bus.res_valid_out && bus.res_ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_WIDTH'(NUM_CH - 1);
      beat_cnt_q   <= '0;
      pend_vld_q   <= 1'b0;
      pend_ch_q    <= '0;
`ifdef POOL_ARB_ERR_EN
      arb_err      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.arb_valid_in) begin
            grant_q <= grant_d;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (last_beat) begin
            beat_cnt_q   <= '0;
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end else if (fire) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A completing window outranks a same-cycle result handshake: the new tag must survive.
      if (last_beat) begin
        pend_vld_q <= 1'b1;
        pend_ch_q  <= grant_q;
      end else if (res_hs) begin
        pend_vld_q <= 1'b0;
      end

`ifdef POOL_ARB_ERR_EN
      if ((bus.res_valid_in && !pend_vld_q) || (last_beat && pend_vld_q && !res_hs)) begin
        arb_err <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_pool_arbiter.sv
// Directed bench for pool_arbiter with a behavioural subsample (sum of POOL_SIZE beats, ready low
// until its result drains) and per-channel scripted sources.
module tb_pool_arbiter;
  localparam int NUM_CH = 4;
  localparam int DW     = 12;
  localparam int PS     = 10;
  localparam int AW     = DW + $clog2(PS);

  logic clk;
  logic rst;
  logic arb_err;

  pool_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .POOL_SIZE(PS)) bus ();

  pool_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .POOL_SIZE(PS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave)
`ifdef POOL_ARB_ERR_EN
    ,
    .arb_err (arb_err)
`endif
  );

`ifndef POOL_ARB_ERR_EN
  assign arb_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Channel sources: cons counts accepted beats, base marks where the current script starts.
  bit [DW-1:0]       src_mem [NUM_CH][64];
  int                cons [NUM_CH];
  int                base [NUM_CH];
  int                len  [NUM_CH];
  bit [NUM_CH-1:0]   hold;

  function automatic int sent(input int c);
    return cons[c] - base[c];
  endfunction

  always_comb begin
    bus.arb_valid_in = '0;
    bus.arb_data_in  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.arb_valid_in[c]          = (sent(c) < len[c]) && !hold[c];
      bus.arb_data_in[c*DW +: DW]  = src_mem[c][sent(c) & 63];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (bus.arb_valid_in[c] && bus.arb_ready_in[c]) cons[c] <= cons[c] + 1;
  end

  // Behavioural subsample.
  int          sub_cnt;
  bit [AW-1:0] sub_sum;
  bit [AW-1:0] sub_res;
  bit          sub_full;
  bit          inj;

  assign bus.arb_ready_out = !sub_full;
  assign bus.res_valid_in  = sub_full | inj;
  assign bus.res_data_in   = sub_res;

  always @(posedge clk) begin
    if (rst) begin
      sub_cnt <= 0; sub_sum <= '0; sub_full <= 1'b0; sub_res <= '0;
    end else begin
      if (sub_full && bus.res_ready_in) sub_full <= 1'b0;
      if (bus.arb_valid_out && bus.arb_ready_out) begin
        if (sub_cnt == PS - 1) begin
          sub_res  <= sub_sum + AW'(bus.arb_data_out);
          sub_full <= 1'b1;
          sub_cnt  <= 0;
          sub_sum  <= '0;
        end else begin
          sub_cnt <= sub_cnt + 1;
          sub_sum <= sub_sum + AW'(bus.arb_data_out);
        end
      end
    end
  end

  int res_dq[$];
  int res_cq[$];
  always @(posedge clk) begin
    if (!rst && bus.res_valid_out && bus.res_ready_out) begin
      res_dq.push_back(int'(bus.res_data_out));
      res_cq.push_back(int'(bus.res_ch_out));
    end
  end

  task automatic load(input int c, input int n, input int first, input int step);
    for (int i = 0; i < n; i++) src_mem[c][i] = DW'(first + i * step);
    base[c] = cons[c];
    len[c]  = n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      base[c] = cons[c];
      len[c]  = 0;
    end
    hold = '0;
    rst  = 1'b0;
    res_dq.delete();
    res_cq.delete();
  endtask

  task automatic wait_res(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && res_dq.size() < n; i++) @(negedge clk);
    check(tag, res_dq.size(), n);
  endtask

  task automatic wait_sent(input string tag, input int c, input int n, input int budget);
    for (int i = 0; i < budget && sent(c) < n; i++) @(negedge clk);
    check(tag, sent(c), n);
  endtask

  task automatic check_res(input string tag, input int i, input int exp_d, input int exp_c);
    check({tag, "_data"}, (i < res_dq.size()) ? res_dq[i] : -1, exp_d);
    check({tag, "_ch"},   (i < res_cq.size()) ? res_cq[i] : -1, exp_c);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    hold = '0;
    inj = 1'b0;
    bus.res_ready_out = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    check("rst_arb_ready_in",  bus.arb_ready_in, 0);
    check("rst_arb_valid_out", bus.arb_valid_out, 0);
    check("rst_arb_data_out",  bus.arb_data_out, 0);
    check("rst_res_ch_out",    bus.res_ch_out, 0);
    check("rst_res_valid_out", bus.res_valid_out, 0);

    // Only ch2 valid, data 1..10: one IDLE cycle, then locked on ch2
    load(2, 10, 1, 1);
    #1;
    check("t1_idle_ready", bus.arb_ready_in, 0);
    @(negedge clk);
    check("t1_grant_ready", bus.arb_ready_in, 4'b0100);
    check("t1_valid_out",   bus.arb_valid_out, 1);
    check("t1_first_data",  bus.arb_data_out, 1);
    wait_res("t1_res_count", 1, 100);
    check_res("t1_res", 0, 55, 2);

    // All channels continuously valid, data = index+1; ch0 has a second window
    do_reset();
    load(0, 20, 1, 0);
    load(1, 10, 2, 0);
    load(2, 10, 3, 0);
    load(3, 10, 4, 0);
    wait_res("t2_res_count", 5, 400);
    check_res("t2_res0", 0, 10, 0);
    check_res("t2_res1", 1, 20, 1);
    check_res("t2_res2", 2, 30, 2);
    check_res("t2_res3", 3, 40, 3);
    check_res("t2_res4", 4, 10, 0);

    // ch1 drops valid after 4 beats while ch3 waits; grant must not move
    do_reset();
    load(1, 10, 1, 1);
    load(3, 10, 7, 0);
    wait_sent("t3_ch1_beats4", 1, 4, 50);
    hold[1] = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.arb_ready_in[3] !== 1'b0 || sent(3) != 0) bad++;
    end
    check("t3_ch3_blocked", bad, 0);
    check("t3_ch1_stalled", sent(1), 4);
    hold[1] = 1'b0;
    wait_res("t3_res_count", 2, 200);
    check_res("t3_res0", 0, 55, 1);
    check_res("t3_res1", 1, 70, 3);

    // Result sink stalled 30 cycles: next window must not consume beats
    do_reset();
    bus.res_ready_out = 1'b0;
    load(0, 10, 2, 0);
    load(1, 10, 5, 0);
    for (int i = 0; i < 100 && !bus.res_valid_out; i++) @(negedge clk);
    check("t4_res_valid", bus.res_valid_out, 1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.arb_ready_out !== 1'b0 || bus.res_ready_in !== 1'b0 || sent(1) != 0 ||
          bus.res_ch_out !== 2'd0 || bus.res_data_out !== AW'(20)) bad++;
    end
    check("t4_stall_held", bad, 0);
    bus.res_ready_out = 1'b1;
    wait_res("t4_res_count", 2, 200);
    check_res("t4_res0", 0, 20, 0);
    check_res("t4_res1", 1, 50, 1);

    // Reset in the middle of a ch0 window
    do_reset();
    load(0, 10, 9, 0);
    wait_sent("t5_ch0_beats5", 0, 5, 50);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ready_in",  bus.arb_ready_in, 0);
    check("t5_rst_valid_out", bus.arb_valid_out, 0);
    load(0, 10, 3, 0);
    rst = 1'b0;
    #1;
    check("t5_idle_after_rst", bus.arb_ready_in, 0);
    wait_res("t5_res_count", 1, 100);
    repeat (15) @(negedge clk);
    check("t5_single_res", res_dq.size(), 1);
    check_res("t5_res", 0, 30, 0);

`ifdef POOL_ARB_ERR_EN
    // Result with no recorded window
    do_reset();
    check("err_rst", arb_err, 0);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    check("err_set", arb_err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", arb_err, 1);
    do_reset();
    check("err_cleared", arb_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pool_arbiter.md
# pool_arbiter

Round-robin scheduler that time-shares one `subsample` pooling accumulator between `NUM_CH` AXI-stream channels.
- Grants one channel exclusive access for a whole pooling window of exactly `POOL_SIZE` accepted beats, so windows from different channels never mix.
- Tags each pooled result with the channel index that produced it.
- Sits between the per-channel convolution outputs and the shared `subsample` instance in the 1D CNN datapath.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels (2..16).
- `DATA_WIDTH`, 12: per-beat data width; must equal the `DATA_WIDTH` of the attached `subsample`.
- `POOL_SIZE`, 10: beats per window; must equal the `POOL_SIZE` of the attached `subsample`.
- Derived `CH_WIDTH` = clog2(`NUM_CH`); `ACC_WIDTH` = `DATA_WIDTH` + clog2(`POOL_SIZE`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arb_valid_in`  in  `NUM_CH`  per-channel valid.
- `arb_ready_in`  out  `NUM_CH`  per-channel ready.
- `arb_data_in`  in  `NUM_CH`*`DATA_WIDTH`  channel i occupies bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `arb_valid_out`  out  1  to `subsample_valid_in`.
- `arb_ready_out`  in  1  from `subsample_ready_in`.
- `arb_data_out`  out  `DATA_WIDTH`  to `subsample_data_in`.
- `res_valid_in`  in  1  from `subsample_valid_out`.
- `res_ready_in`  out  1  to `subsample_ready_out`.
- `res_data_in`  in  `ACC_WIDTH`  from `subsample_data_out`.
- `res_valid_out`  out  1  tagged result valid.
- `res_ready_out`  in  1  downstream ready.
- `res_data_out`  out  `ACC_WIDTH`  pooled sum.
- `res_ch_out`  out  `CH_WIDTH`  channel index of `res_data_out`.

## Operation
- State machine, two states:
  - IDLE: no grant; all `arb_ready_in` = 0; `arb_valid_out` = 0.
  - LOCK: `grant` register selects a channel.
- IDLE -> LOCK: if any `arb_valid_in` bit is set, register `grant` = first valid index searching from `last_grant`+1 upward, wrapping modulo `NUM_CH`. Otherwise stay in IDLE.
- LOCK forwarding, purely combinational:
  - `arb_valid_out` = `arb_valid_in[grant]`.
  - `arb_data_out` = channel `grant` data.
  - `arb_ready_in[grant]` = `arb_ready_out`; all other `arb_ready_in` bits = 0.
- Beat counter `beat_cnt` (clog2(`POOL_SIZE`) bits) increments on each `arb_valid_out && arb_ready_out`.
- On the handshake where `beat_cnt` == `POOL_SIZE`-1:
  - `beat_cnt` <= 0; `last_grant` <= `grant`; state <= IDLE.
  - `pend_ch` <= `grant`; `pend_vld` <= 1.
- The grant is never released mid-window. If the granted channel drops valid, the arbiter waits with no timeout.
- Result path is combinational pass-through:
  - `res_valid_out` = `res_valid_in`; `res_data_out` = `res_data_in`.
  - `res_ready_in` = `res_ready_out`; `res_ch_out` = `pend_ch`.
  - Output handshake clears `pend_vld`.
- At most one result is ever pending, because `subsample` holds ready low until its result drains. `pend_ch` therefore needs only one entry.
- Window completion and result handshake in the same cycle: `pend_vld` <= 1 and `pend_ch` <= new grant; the completion wins.
- The next window may be granted while a result is pending; it stalls naturally on `arb_ready_out` = 0.

## Timing
- Reset values:
  - state = IDLE; `grant` = 0; `last_grant` = `NUM_CH`-1, so channel 0 wins first.
  - `beat_cnt` = 0; `pend_vld` = 0; `pend_ch` = 0.
  - All `arb_ready_in` = 0; `arb_valid_out` = 0; `arb_data_out` = 0.
  - `res_ch_out` = 0 (`res_valid_out` and `res_ready_in` follow their inputs).
- Grant latency: 1 cycle from `arb_valid_in` seen in IDLE to the first possible forwarded beat.
- One dead IDLE cycle between consecutive windows.
- Zero-cycle forward latency through the arbiter in both directions. The end-to-end `subsample` latency is unchanged.
- Reset mid-window: next cycle is IDLE with `beat_cnt` = 0 and `pend_vld` = 0. The shared `rst` also clears `subsample`, so no partial sum survives.

## Configuration
- `POOL_ARB_ERR_EN` defined:
  - Adds output `arb_err` (1 bit, reset 0), sticky until `rst`.
  - Sets when `res_valid_in` = 1 while `pend_vld` = 0 (result with no recorded window).
  - Also sets when a window completes while `pend_vld` = 1 and no result handshake happens that cycle (tag overwrite).
- Not defined: port and logic absent; both conditions go unchecked.

## Test plan
- Reset, then only ch2 valid with data 1..10, `POOL_SIZE`=10 -> first grant to ch2 one cycle later; `res_data_out`=55 with `res_ch_out`=2.
- All 4 channels valid continuously, data = channel index + 1 -> windows granted in order 0,1,2,3,0; results 10,20,30,40 tagged 0,1,2,3.
- ch1 granted, valid drops after beat 4 for 20 cycles while ch3 is valid -> ch3 `arb_ready_in` stays 0; ch1 completes with beats 5..10 before ch3 is granted.
- `res_ready_out` held low for 30 cycles after a window -> `arb_ready_out` low, next window stalls; no beats lost; tags remain in order.
- `rst` pulsed at beat 6 of a ch0 window -> IDLE, all `arb_ready_in`=0; post-reset ch0 window of ten 3s yields 30.
- `POOL_ARB_ERR_EN`: drive `res_valid_in`=1 with no window sent -> `arb_err`=1 next cycle, held until `rst`.
